// File: rtl/pipe_pkg.sv
// Shared types for the elastic inter-stage pipeline register.
// Header fields, FSM state encoding and the canonical NOP.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        PR_EMPTY,
        PR_FULL,
        PR_SKID
    } pipe_reg_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } pipe_hdr_t;

endpackage

// File: rtl/elastic_pipe_reg.sv
// Valid/ready pipeline register with optional 2-entry skid and flush.
// Main entry drives the outputs; the skid entry absorbs one beat of backpressure.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 72,
    parameter bit          SKID_EN   = 1'b1,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [31:0]          in_instr_i,
    input  logic [31:0]          in_pc_i,
    input  logic [PAYLOAD_W-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [31:0]          out_instr_o,
    output logic [31:0]          out_pc_o,
    output logic [PAYLOAD_W-1:0] out_data_o
);

    pipe_reg_state_e        state_q;
    pipe_reg_state_e        state_d;
    pipe_hdr_t              main_hdr_q;
    logic [PAYLOAD_W-1:0]   main_data_q;
    pipe_hdr_t              skid_hdr;
    logic [PAYLOAD_W-1:0]   skid_data;
    pipe_hdr_t              in_hdr;
    logic                   in_xfer;
    logic                   out_xfer;
    logic                   load_main_in;
    logic                   load_main_skid;
    logic                   load_skid;

    assign in_hdr      = '{instr: in_instr_i, pc: in_pc_i};
    assign out_valid_o = (state_q != PR_EMPTY);
    assign in_xfer     = in_valid_i & in_ready_o;
    assign out_xfer    = out_valid_o & out_ready_i;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            PR_EMPTY: begin
                if (in_xfer) begin
                    state_d      = PR_FULL;
                    load_main_in = 1'b1;
                end
            end
            PR_FULL: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (out_xfer) begin
                    state_d = PR_EMPTY;
                end else if (in_xfer) begin
                    state_d   = PR_SKID;
                    load_skid = 1'b1;
                end
            end
            PR_SKID: begin
                if (out_xfer) begin
                    state_d        = PR_FULL;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = PR_EMPTY;
        endcase
        // Flush drops everything held and any same-cycle input.
        if (flush_i) begin
            state_d        = PR_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= PR_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            main_hdr_q  <= '0;
            main_data_q <= '0;
        end else if (load_main_in) begin
            main_hdr_q  <= in_hdr;
            main_data_q <= in_data_i;
        end else if (load_main_skid) begin
            main_hdr_q  <= skid_hdr;
            main_data_q <= skid_data;
        end
    end

    assign out_instr_o = out_valid_o ? main_hdr_q.instr : NOP_INSTR;
    assign out_pc_o    = main_hdr_q.pc;
    assign out_data_o  = main_data_q;

    if (SKID_EN) begin : g_skid
        pipe_hdr_t            hdr_q;
        logic [PAYLOAD_W-1:0] data_q;
        logic                 rdy_q;

        // Ready is a flop: it only depends on where the FSM is heading.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                hdr_q  <= '0;
                data_q <= '0;
                rdy_q  <= 1'b1;
            end else begin
                if (load_skid) begin
                    hdr_q  <= in_hdr;
                    data_q <= in_data_i;
                end
                rdy_q <= (state_d != PR_SKID);
            end
        end

        assign skid_hdr   = hdr_q;
        assign skid_data  = data_q;
        assign in_ready_o = rdy_q;
    end else begin : g_noskid
        assign skid_hdr   = '0;
        assign skid_data  = '0;
        assign in_ready_o = ~out_valid_o | out_ready_i;
    end

endmodule
